// File: rtl/movegen_board_serialiser.sv
// Double-buffered board serialiser: accepts packed positions and streams 64 square beats a1..h8.
// Optional MOVEGEN_SER_FLIP_EN mirrors black-to-move positions so downstream always sees white to move.
module movegen_board_serialiser #(
    parameter int PIECE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_board_valid,
    output logic                 in_board_ready,
    input  logic [64*PIECE_W-1:0] in_board,
    input  logic                 in_board_wtm,
    input  logic                 out_pos_hold,
    output logic                 out_pos_valid,
    output logic                 out_pos_sop,
    output logic                 out_pos_eop,
    output logic [PIECE_W-1:0]   out_pos_piece,
    output logic                 out_pos_wtm
);

    typedef enum logic [1:0] {
        EMPTY,
        STREAM,
        STREAM_PEND
    } state_t;

    state_t state, state_next;

    logic [64*PIECE_W-1:0] active_board, pend_board;
    logic                  active_wtm, pend_wtm;
    logic [5:0]            sq;
    logic                  active_full, pend_full;
    logic                  beat, eop_beat, accept, accept_active, accept_pend;

    assign active_full   = (state != EMPTY);
    assign pend_full     = (state == STREAM_PEND);
    assign beat          = active_full && !out_pos_hold;
    assign eop_beat      = beat && (sq == 6'd63);
    assign in_board_ready = !pend_full;
    assign accept        = in_board_valid && in_board_ready;
    // A board arriving on the final beat with nothing queued goes straight to ACTIVE so sop follows with no gap.
    assign accept_active = accept && (!active_full || (eop_beat && !pend_full));
    assign accept_pend   = accept && !accept_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) state_next = STREAM;
            end
            STREAM: begin
                if (eop_beat) begin
                    if (!accept) state_next = EMPTY;
                end else if (accept) begin
                    state_next = STREAM_PEND;
                end
            end
            STREAM_PEND: begin
                if (eop_beat) state_next = STREAM;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Draining PENDING zeroes it, so an idle ACTIVE slot holds an all-empty board and wtm 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq           <= '0;
            active_board <= '0;
            active_wtm   <= 1'b0;
            pend_board   <= '0;
            pend_wtm     <= 1'b0;
        end else begin
            if (beat) sq <= sq + 6'd1;
            if (accept_active) begin
                active_board <= in_board;
                active_wtm   <= in_board_wtm;
            end else if (eop_beat) begin
                active_board <= pend_board;
                active_wtm   <= pend_wtm;
            end
            if (accept_pend) begin
                pend_board <= in_board;
                pend_wtm   <= in_board_wtm;
            end else if (eop_beat) begin
                pend_board <= '0;
                pend_wtm   <= 1'b0;
            end
        end
    end

    logic [5:0]         rd_sq;
    logic [PIECE_W-1:0] raw_piece;

`ifdef MOVEGEN_SER_FLIP_EN
    logic flip;
    assign flip      = !active_wtm;
    assign rd_sq     = flip ? (sq ^ 6'd56) : sq;
    assign raw_piece = active_board[int'(rd_sq)*PIECE_W +: PIECE_W];
    always_comb begin
        out_pos_piece = raw_piece;
        if (flip) begin
            if (raw_piece[2:0] == 3'd0) out_pos_piece = '0;
            else out_pos_piece = raw_piece ^ {1'b1, {(PIECE_W-1){1'b0}}};
        end
    end
`else
    assign rd_sq         = sq;
    assign raw_piece     = active_board[int'(rd_sq)*PIECE_W +: PIECE_W];
    assign out_pos_piece = raw_piece;
`endif

    assign out_pos_valid = beat;
    assign out_pos_sop   = beat && (sq == 6'd0);
    assign out_pos_eop   = eop_beat;
    assign out_pos_wtm   = active_wtm;

endmodule
